// File: rtl/jk_counter_pkg.sv
// Shared definitions for the JK-cell modulo counter: cell excitation encodings
// and the next-count function used by the top-level excitation logic.
package jk_counter_pkg;

    localparam int unsigned MAX_WIDTH = 8;
    localparam int unsigned CW        = MAX_WIDTH + 1;

    typedef logic [CW-1:0] cnt_t;

    // {J, K} encodings
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // One wider than any legal WIDTH so modulus == 2**WIDTH is representable.
    function automatic cnt_t next_count(input cnt_t q, input logic up, input cnt_t modulus);
        cnt_t nxt;
        if (q >= modulus) begin
            nxt = '0;
        end else if (up) begin
            nxt = (q == modulus - cnt_t'(1)) ? '0 : q + cnt_t'(1);
        end else begin
            nxt = (q == '0) ? modulus - cnt_t'(1) : q - cnt_t'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// Edge-triggered JK flip-flop with asynchronous active-high reset.
module jk_ff_cell
    import jk_counter_pkg::*;
(
    input  logic C,
    input  logic RESET,
    input  logic J,
    input  logic K,
    output logic Q
);

    always_ff @(posedge C or posedge RESET) begin
        if (RESET) begin
            Q <= 1'b0;
        end else begin
            unique case ({J, K})
                JK_HOLD:   Q <= Q;
                JK_RESET:  Q <= 1'b0;
                JK_SET:    Q <= 1'b1;
                JK_TOGGLE: Q <= ~Q;
            endcase
        end
    end

endmodule

// File: rtl/jk_mod_updown_counter.sv
// Modulo-N up/down counter built from JK cells: per-bit J/K excitation, load with
// range check, terminal-count decode and registered wrap / load-error pulses.
module jk_mod_updown_counter
    import jk_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             C,
    input  logic             RESET,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             TC,
    output logic             WRAP,
    output logic             LOAD_ERR
);

    localparam cnt_t MOD     = cnt_t'(MODULUS);
    localparam cnt_t TOP_VAL = cnt_t'(MODULUS - 1);

    cnt_t             q_ext;
    cnt_t             d_ext;
    cnt_t             nxt_ext;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             load_ok;
    logic             illegal;
    logic             wrap_take;
    logic             wrap_d;
    logic             load_err_d;
    logic             unused_nxt_hi;

    assign q_ext         = cnt_t'(Q);
    assign d_ext         = cnt_t'(D);
    assign nxt_ext       = next_count(q_ext, UP, MOD);
    assign nxt           = nxt_ext[WIDTH-1:0];
    // Upper bits are always zero for a legal modulus.
    assign unused_nxt_hi = ^nxt_ext[CW-1:WIDTH];

    assign load_ok   = (d_ext < MOD);
    assign illegal   = (q_ext >= MOD);
    assign wrap_take = illegal | (UP ? (q_ext == TOP_VAL) : (q_ext == '0));

    assign TC = EN & (UP ? (q_ext == TOP_VAL) : (q_ext == '0));
    assign Qn = ~Q;

    always_comb begin
        j          = '0;
        k          = '0;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (LOAD) begin
            if (load_ok) begin
                j = D;
                k = ~D;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (EN) begin
            // Toggle exactly the bits that differ from the next count.
            j      = nxt ^ Q;
            k      = nxt ^ Q;
            wrap_d = wrap_take;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_ff_cell u_cell (
            .C     (C),
            .RESET (RESET),
            .J     (j[i]),
            .K     (k[i]),
            .Q     (Q[i])
        );
    end

    always_ff @(posedge C or posedge RESET) begin
        if (RESET) begin
            WRAP     <= 1'b0;
            LOAD_ERR <= 1'b0;
        end else begin
            WRAP     <= wrap_d;
            LOAD_ERR <= load_err_d;
        end
    end

endmodule

// File: tb/tb_jk_mod_updown_counter.sv
// Scoreboard bench: a MODULUS=10 and a MODULUS=16 counter share stimulus and are
// compared against a behavioural model after every clock edge.
module tb_jk_mod_updown_counter;

    typedef struct {
        int unsigned dut;
        logic [3:0]  q;
        logic        wrap;
        logic        lerr;
    } exp_t;

    logic       C;
    logic       RESET;
    logic       EN;
    logic       UP;
    logic       LOAD;
    logic [3:0] D;
    logic [3:0] q10, qn10, q16, qn16;
    logic       tc10, wrap10, lerr10, tc16, wrap16, lerr16;

    int unsigned errors = 0;
    int unsigned checks = 0;
    exp_t        sb[$];
    int          mq[2];
    bit          mw[2];
    bit          ml[2];
    int          mods[2] = '{10, 16};

    jk_mod_updown_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
        .C(C), .RESET(RESET), .EN(EN), .UP(UP), .LOAD(LOAD), .D(D),
        .Q(q10), .Qn(qn10), .TC(tc10), .WRAP(wrap10), .LOAD_ERR(lerr10)
    );

    jk_mod_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .C(C), .RESET(RESET), .EN(EN), .UP(UP), .LOAD(LOAD), .D(D),
        .Q(q16), .Qn(qn16), .TC(tc16), .WRAP(wrap16), .LOAD_ERR(lerr16)
    );

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i] = 0;
            mw[i] = 1'b0;
            ml[i] = 1'b0;
        end
    endtask

    task automatic check_reset_state();
        check("rst_q10", 32'(q10), 32'h0);
        check("rst_qn10", 32'(qn10), 32'hf);
        check("rst_wrap10", 32'(wrap10), 32'h0);
        check("rst_lerr10", 32'(lerr10), 32'h0);
        check("rst_q16", 32'(q16), 32'h0);
        check("rst_qn16", 32'(qn16), 32'hf);
        check("rst_wrap16", 32'(wrap16), 32'h0);
        check("rst_lerr16", 32'(lerr16), 32'h0);
    endtask

    task automatic pop_and_compare();
        exp_t       e;
        logic [3:0] eqn;
        for (int n = 0; n < 2; n++) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got 0 entries expected 1");
            end else begin
                e   = sb.pop_front();
                eqn = ~e.q;
                if (e.dut == 0) begin
                    check("q10", 32'(q10), 32'(e.q));
                    check("qn10", 32'(qn10), 32'(eqn));
                    check("wrap10", 32'(wrap10), 32'(e.wrap));
                    check("lerr10", 32'(lerr10), 32'(e.lerr));
                end else begin
                    check("q16", 32'(q16), 32'(e.q));
                    check("qn16", 32'(qn16), 32'(eqn));
                    check("wrap16", 32'(wrap16), 32'(e.wrap));
                    check("lerr16", 32'(lerr16), 32'(e.lerr));
                end
            end
        end
    endtask

    // Entered and left on a falling edge of C.
    task automatic step(input bit en, input bit up, input bit ld, input logic [3:0] d);
        bit exp_tc;
        EN   = en;
        UP   = up;
        LOAD = ld;
        D    = d;
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_tc = en && (up ? (mq[i] == mods[i] - 1) : (mq[i] == 0));
            if (i == 0) check("tc10", 32'(tc10), 32'(exp_tc));
            else        check("tc16", 32'(tc16), 32'(exp_tc));
            if (ld) begin
                mw[i] = 1'b0;
                if (int'(d) < mods[i]) begin
                    mq[i] = int'(d);
                    ml[i] = 1'b0;
                end else begin
                    ml[i] = 1'b1;
                end
            end else if (en) begin
                ml[i] = 1'b0;
                if (up) begin
                    mw[i] = (mq[i] == mods[i] - 1);
                    mq[i] = mw[i] ? 0 : mq[i] + 1;
                end else begin
                    mw[i] = (mq[i] == 0);
                    mq[i] = mw[i] ? mods[i] - 1 : mq[i] - 1;
                end
            end else begin
                mw[i] = 1'b0;
                ml[i] = 1'b0;
            end
            sb.push_back('{dut: i, q: 4'(mq[i]), wrap: mw[i], lerr: ml[i]});
        end
        @(posedge C);
        #1;
        pop_and_compare();
        @(negedge C);
    endtask

    initial begin
        RESET = 1'b1;
        EN    = 1'b0;
        UP    = 1'b0;
        LOAD  = 1'b0;
        D     = '0;
        model_reset();
        #12;
        check_reset_state();
        @(negedge C);
        RESET = 1'b0;

        // Up count through the wrap
        repeat (12) step(1'b1, 1'b1, 1'b0, 4'd0);

        // Load then count down through the wrap
        step(1'b0, 1'b0, 1'b1, 4'd7);
        repeat (9) step(1'b1, 1'b0, 1'b0, 4'd0);

        // Out-of-range load is rejected only by the MODULUS=10 counter
        step(1'b0, 1'b0, 1'b1, 4'd3);
        step(1'b0, 1'b0, 1'b1, 4'd12);
        step(1'b0, 1'b0, 1'b1, 4'd5);

        // Load beats enable, then hold
        step(1'b0, 1'b0, 1'b1, 4'd8);
        step(1'b1, 1'b1, 1'b1, 4'd2);
        repeat (3) step(1'b0, 1'b1, 1'b0, 4'd0);

        // Asynchronous reset in mid-cycle
        step(1'b0, 1'b0, 1'b1, 4'd6);
        EN   = 1'b0;
        LOAD = 1'b0;
        #2;
        RESET = 1'b1;
        #1;
        model_reset();
        check_reset_state();
        @(posedge C);
        #1;
        check_reset_state();
        @(negedge C);
        RESET = 1'b0;
        step(1'b1, 1'b1, 1'b0, 4'd0);

        // Full-range wrap at all-ones and at zero
        step(1'b0, 1'b0, 1'b1, 4'd14);
        step(1'b1, 1'b1, 1'b0, 4'd0);
        step(1'b1, 1'b1, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0);

        repeat (60) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
